// File: rtl/apb_master_arbiter.sv
// APB master shared by two command requesters. Commands are accepted one at a
// time over valid/ready and granted round-robin. The block drives the APB
// SETUP/ACCESS phases, waits on PREADY with an optional bounded timeout, and
// returns read data or a timeout flag to the requester that issued the command.
module apb_master_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp0_timeout,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          rsp1_timeout,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic          PREADY,
  input  logic [DW-1:0] PRDATA,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic          last_grant;
  logic          owner;
  logic          grant;
  logic          accept;
  logic          expired;
  logic [CW-1:0] wcnt;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = !PRESET && (state == IDLE) && !grant && req0_valid;
  assign req1_ready = !PRESET && (state == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;

  // Abort condition for the current ACCESS cycle; TIMEOUT == 0 never expires.
  assign expired = (TIMEOUT != 0) && !PREADY && (wcnt == CW'(TIMEOUT - 1));

  // Transfer sequencer: all APB and response outputs are registered here.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      wcnt         <= '0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      busy         <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp0_timeout <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= '0;
      rsp1_timeout <= 1'b0;
    end else begin
      // Responses are single-cycle pulses; data is zero whenever not valid.
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp0_timeout <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= '0;
      rsp1_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SETUP;
            PSEL       <= 1'b1;
            busy       <= 1'b1;
            owner      <= grant;
            last_grant <= grant;
            PWRITE     <= grant ? req1_write : req0_write;
            PADDR      <= grant ? req1_addr  : req0_addr;
            PWDATA     <= grant ? req1_wdata : req0_wdata;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          wcnt    <= '0;
        end
        ACCESS: begin
          if (PREADY || expired) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
            if (owner) begin
              rsp1_valid   <= 1'b1;
              rsp1_timeout <= !PREADY;
              rsp1_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
            end else begin
              rsp0_valid   <= 1'b1;
              rsp0_timeout <= !PREADY;
              rsp0_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter. The reference model works at the
// transaction level: each accepted command gets a pre-drawn number of PREADY
// wait states, and its whole bus timeline (SETUP, ACCESS window, response
// cycle) follows from the accept cycle by arithmetic.
module tb_apb_master_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int NCYC = 4000;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp0_timeout, rsp1_valid, rsp1_timeout;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, busy;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  logic [1:0]    v, w;
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];

  apb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_write(w[0]),
    .req0_addr(ad[0]), .req0_wdata(wd[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_write(w[1]),
    .req1_addr(ad[1]), .req1_wdata(wd[1]),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_timeout(rsp0_timeout),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_timeout(rsp1_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Transaction model state
  bit            have;        // a command has been accepted since reset
  int            ta, tn, tk;  // accept cycle, wait states, ACCESS cycles
  bit            towner, twrite;
  logic [DW-1:0] trd;
  bit            cur_write;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  bit            last;
  bit            acc [2];
  bit            rst_now, rst_done;
  bit            busy_m, e_pen, e_rv, e_to;
  bit            e_rdy [2];
  logic [DW-1:0] e_rd;
  int            j, prob;

  initial begin
    PRESET = 1'b1; v = '0; w = '0;
    ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    PREADY = 1'b0; PRDATA = '0;
    have = 0; last = 1; cur_write = 0; cur_addr = '0; cur_wdata = '0;
    acc[0] = 0; acc[1] = 0; rst_done = 0;
    ta = 0; tn = 0; tk = 0; towner = 0; twrite = 0; trd = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge PCLK); #1;
      // ---- drive inputs for this cycle ----
      rst_now = (cyc < 3);
      // One reset landing in the 2nd ACCESS cycle of a transfer with waits.
      if (!rst_done && cyc > 2000 && have && tn >= 1 && cyc == ta + 3) begin
        rst_now  = 1;
        rst_done = 1;
      end
      PRESET = rst_now;
      prob = (cyc < 60) ? 100 : 40;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin v[i] = 1'b0; acc[i] = 0; end
        if (!v[i] && (($urandom_range(0, 99) < prob) || (rst_now && cyc > 3))) begin
          v[i]  = 1'b1;
          w[i]  = 1'($urandom_range(0, 1));
          ad[i] = $urandom & 32'h0000_FFFC;
          wd[i] = $urandom;
        end
      end
      if (have && cyc >= ta + 2 && cyc < ta + 2 + tk) begin
        j      = cyc - ta - 2;
        PREADY = (j == tn);
        PRDATA = (j == tn) ? trd : $urandom;
      end else begin
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end

      @(negedge PCLK);
      // ---- expected outputs for this cycle ----
      busy_m = have && (cyc < ta + 2 + tk);
      e_pen  = have && (cyc >= ta + 2) && (cyc < ta + 2 + tk);
      e_rv   = have && (cyc == ta + 2 + tk);
      e_to   = (tn >= TO);
      e_rd   = (twrite || e_to) ? '0 : trd;
      for (int i = 0; i < 2; i++) begin
        if (rst_now || busy_m || !v[i]) e_rdy[i] = 0;
        else if (v[0] && v[1])          e_rdy[i] = (i != int'(last));
        else                            e_rdy[i] = 1;
      end
      chk("req0_ready", 64'(req0_ready), 64'(e_rdy[0]));
      chk("req1_ready", 64'(req1_ready), 64'(e_rdy[1]));
      chk("busy",       64'(busy),       64'(busy_m));
      chk("psel",       64'(PSEL),       64'(busy_m));
      chk("penable",    64'(PENABLE),    64'(e_pen));
      chk("pwrite",     64'(PWRITE),     64'(cur_write));
      chk("paddr",      64'(PADDR),      64'(cur_addr));
      chk("pwdata",     64'(PWDATA),     64'(cur_wdata));
      chk("rsp0_valid",   64'(rsp0_valid),   64'(e_rv && !towner));
      chk("rsp0_timeout", 64'(rsp0_timeout), 64'(e_rv && !towner && e_to));
      chk("rsp0_rdata",   64'(rsp0_rdata),   64'((e_rv && !towner) ? e_rd : '0));
      chk("rsp1_valid",   64'(rsp1_valid),   64'(e_rv && towner));
      chk("rsp1_timeout", 64'(rsp1_timeout), 64'(e_rv && towner && e_to));
      chk("rsp1_rdata",   64'(rsp1_rdata),   64'((e_rv && towner) ? e_rd : '0));

      // ---- advance the model ----
      if (rst_now) begin
        have = 0; last = 1;
        cur_write = 0; cur_addr = '0; cur_wdata = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (e_rdy[i]) begin
            acc[i]    = 1;
            have      = 1;
            ta        = cyc;
            towner    = (i == 1);
            twrite    = w[i];
            cur_write = w[i];
            cur_addr  = ad[i];
            cur_wdata = wd[i];
            last      = (i == 1);
            trd       = $urandom;
            if (cyc < 60)                       tn = 0;
            else if ($urandom_range(0, 7) == 0) tn = $urandom_range(TO - 1, TO + 4);
            else                                tn = $urandom_range(0, 3);
            tk = (tn >= TO) ? TO : tn + 1;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
